seq_divider_16bit: RTL and testbench

//   Multi-cycle unsigned restoring divider for the ALU, the subtractive counterpart of the
//   CLA adder path: each iteration is a trial subtraction of the divisor from a partial

---
 rtl/seq_divider_16bit.sv | 115 +++++++++++
 tb/tb_seq_divider_16bit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock after a start pulse,
// with a one-cycle done pulse and results held until the next completion.
module seq_divider_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;

   logic [WIDTH:0]   remShift_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH-1:0] quo_d;

   // One restoring step: shift {R,Q} left, trial-subtract, keep the result only if non-negative.
   always_comb begin
      remShift_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial_d    = remShift_d - {1'b0, dsr_q};
      rem_d      = remShift_d;
      quo_d      = {quo_q[WIDTH-2:0], 1'b0};
      if (!trial_d[WIDTH]) begin
         rem_d = trial_d;
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM with registered status outputs and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  if (divisor_i != '0) begin
                     dsr_q   <= divisor_i;
                     rem_q   <= '0;
                     quo_q   <= dividend_i;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     // Zero divisor resolves immediately without spending RUN cycles.
                     quotient_q  <= '1;
                     remainder_q <= dividend_i;
                     dbz_q       <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quotient_q  <= quo_d;
                  remainder_q <= rem_d[WIDTH-1:0];
                  dbz_q       <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed and randomised checks of seq_divider_16bit: results, latency, done pulse,
// ignored mid-run starts, back-to-back starts and reset abort.
module tb_seq_divider_16bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        divByZero;

   int checks;
   int errors;

   seq_divider_16bit #(.WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .busy_o        (busy),
      .done_o        (done),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .div_by_zero_o (divByZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen (or after a bound).
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                output int lat, output int busyCnt);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      lat     = 1;
      busyCnt = 0;
      while (!done && lat < 40) begin
         if (busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic checkResult(input string tag, input logic [15:0] expQ, input logic [15:0] expR,
                              input logic expZ, input int lat, input int expLat);
      checkOutput({tag, "_lat"}, lat, expLat);
      checkOutput({tag, "_done"}, done, 1'b1);
      checkOutput({tag, "_q"}, quotient, expQ);
      checkOutput({tag, "_r"}, remainder, expR);
      checkOutput({tag, "_dbz"}, divByZero, expZ);
   endtask

   initial begin
      int lat;
      int busyCnt;
      int doneSeen;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] recon;

      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_q", quotient, 16'd0);
      checkOutput("rst_r", remainder, 16'd0);
      checkOutput("rst_dbz", divByZero, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // 100/7: busy for 16 cycles, done in cycle 17, single-cycle done
      applyStimulus(16'd100, 16'd7, lat, busyCnt);
      checkResult("d100_7", 16'd14, 16'd2, 1'b0, lat, 17);
      checkOutput("d100_7_busycnt", busyCnt, 16);
      checkOutput("d100_7_busy_at_done", busy, 1'b0);
      @(negedge clk);
      checkOutput("d100_7_done_pulse", done, 1'b0);
      checkOutput("d100_7_hold_q", quotient, 16'd14);
      checkOutput("d100_7_hold_r", remainder, 16'd2);

      applyStimulus(16'hFFFF, 16'h0001, lat, busyCnt);
      checkResult("dffff_1", 16'hFFFF, 16'd0, 1'b0, lat, 17);
      @(negedge clk);
      applyStimulus(16'd3, 16'd10, lat, busyCnt);
      checkResult("d3_10", 16'd0, 16'd3, 1'b0, lat, 17);
      @(negedge clk);
      applyStimulus(16'hFFFF, 16'hFFFF, lat, busyCnt);
      checkResult("dffff_ffff", 16'd1, 16'd0, 1'b0, lat, 17);
      @(negedge clk);

      // Zero divisor resolves in one cycle; a following valid divide clears the flag
      applyStimulus(16'd5, 16'd0, lat, busyCnt);
      checkResult("d5_0", 16'hFFFF, 16'd5, 1'b1, lat, 1);
      checkOutput("d5_0_busycnt", busyCnt, 0);
      @(negedge clk);
      checkOutput("d5_0_done_pulse", done, 1'b0);
      checkOutput("d5_0_hold_dbz", divByZero, 1'b1);
      applyStimulus(16'd9, 16'd3, lat, busyCnt);
      checkResult("d9_3", 16'd3, 16'd0, 1'b0, lat, 17);
      @(negedge clk);

      // 1000/3 with an ignored start at RUN cycle 5
      dividend = 16'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      dividend = 16'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("midrun_busy", busy, 1'b1);
      checkOutput("midrun_hold_q", quotient, 16'd3);
      lat = 6;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkResult("d1000_3", 16'd333, 16'd1, 1'b0, lat, 17);

      // Back-to-back start in the DONE cycle
      applyStimulus(16'd50, 16'd5, lat, busyCnt);
      checkOutput("b2b_busycnt", busyCnt, 16);
      checkResult("d50_5", 16'd10, 16'd0, 1'b0, lat, 17);
      @(negedge clk);

      // Reset at RUN cycle 8 aborts with no done pulse
      dividend = 16'd40000;
      divisor  = 16'd123;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("abort_busy_before", busy, 1'b1);
      checkOutput("abort_hold_q", quotient, 16'd10);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_done", done, 1'b0);
      checkOutput("abort_q", quotient, 16'd0);
      checkOutput("abort_r", remainder, 16'd0);
      checkOutput("abort_dbz", divByZero, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) doneSeen = 1;
      end
      checkOutput("abort_no_done", doneSeen, 0);
      checkOutput("abort_idle_busy", busy, 1'b0);
      applyStimulus(16'd40000, 16'd123, lat, busyCnt);
      checkResult("d40000_123", 16'd325, 16'd25, 1'b0, lat, 17);

      // Randomised operands including 0 and 0xFFFF, issued back-to-back
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 5))
            0:       a = 16'd0;
            1:       a = 16'hFFFF;
            default: a = 16'($urandom);
         endcase
         case ($urandom_range(0, 6))
            0:       b = 16'd0;
            1:       b = 16'hFFFF;
            2:       b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         applyStimulus(a, b, lat, busyCnt);
         if (b == 16'd0) begin
            checkResult("rand_zero", 16'hFFFF, a, 1'b1, lat, 1);
         end else begin
            checkResult("rand", a / b, a % b, 1'b0, lat, 17);
            recon = 32'(quotient) * 32'(b) + 32'(remainder);
            checkOutput("rand_invariant", recon, 32'(a));
            checkOutput("rand_rem_lt_div", 32'(remainder < b), 32'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
